// File: rtl/ibuf_issue_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// ibuf_issue_scoreboard_pkg
// Shared definitions for the issue-slot scoreboard: default sizing, the
// stall-counter width and the helper that sizes warp-within-slot indices.
// ----------------------------------------------------------------------------
package ibuf_issue_scoreboard_pkg;

  localparam int DEF_NUM_WARPS     = 4;
  localparam int DEF_NUM_REGS      = 64;
  localparam int DEF_PAYLOADW      = 128;
  localparam int DEF_STALL_TIMEOUT = 65535;

  // Width of the externally visible hazard-stall counter.
  localparam int STALL_CNT_W = 16;

  // Width of a warp-within-slot index; a single warp still gets one bit so
  // the ports never collapse to zero width.
  function automatic int wis_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  // Global warp id <-> warp-within-slot mapping for a given issue slot.
  function automatic int wis_to_wid(input int wis, input int isw, input int issue_width);
    return wis * issue_width + isw;
  endfunction

  function automatic int wid_to_wis(input int wid, input int issue_width);
    return wid / issue_width;
  endfunction

endpackage

// File: rtl/ibuf_issue_scoreboard_if.sv
// ----------------------------------------------------------------------------
// ibuf_issue_scoreboard_if
// One instruction-issue channel (valid/ready plus decoded register fields and
// an opaque payload). Used both for the instruction-buffer head (scoreboard
// is the slave) and for the dispatch output (scoreboard is the master).
//   valid   : producer has an entry
//   ready   : consumer takes it this cycle
//   wis     : warp index within the issue slot
//   wb      : entry writes rd
//   rd/rs1/rs2/rs3 : register indices
//   payload : passthrough bits
// ----------------------------------------------------------------------------
interface ibuf_issue_scoreboard_if
  import ibuf_issue_scoreboard_pkg::*;
#(
  parameter int WIS_W    = wis_bits(DEF_NUM_WARPS),
  parameter int NR_BITS  = $clog2(DEF_NUM_REGS),
  parameter int PAYLOADW = DEF_PAYLOADW
);
  logic                valid;
  logic                ready;
  logic [WIS_W-1:0]    wis;
  logic                wb;
  logic [NR_BITS-1:0]  rd;
  logic [NR_BITS-1:0]  rs1;
  logic [NR_BITS-1:0]  rs2;
  logic [NR_BITS-1:0]  rs3;
  logic [PAYLOADW-1:0] payload;

  modport master (
    output valid, wis, wb, rd, rs1, rs2, rs3, payload,
    input  ready
  );

  modport slave (
    input  valid, wis, wb, rd, rs1, rs2, rs3, payload,
    output ready
  );
endinterface

// File: rtl/ibuf_issue_scoreboard_pipe_reg.sv
// ----------------------------------------------------------------------------
// ibuf_issue_scoreboard_pipe_reg
// Enable-gated data register for the dispatch output stage. Valid is tracked
// by the parent so this block only carries the data word.
//   clk, reset : clock, synchronous active-high reset (clears data)
//   enable     : load data_in this cycle
//   data_in    : next data word
//   data_out   : registered data word
// ----------------------------------------------------------------------------
module ibuf_issue_scoreboard_pipe_reg #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out
);
  logic [DATAW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (enable) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;
endmodule

// File: rtl/ibuf_issue_scoreboard.sv
// ----------------------------------------------------------------------------
// ibuf_issue_scoreboard
// Consumer end of one instruction-buffer issue slot. The head entry is held
// until none of its source registers (nor its destination, if it writes one)
// has a pending write, then it is moved into a one-entry output register for
// dispatch. A per-warp busy bitmap is set on issue and cleared by writeback;
// a writeback in the same cycle already unblocks the head entry.
//   clk, reset   : clock, synchronous active-high reset
//   ibuf         : instruction-buffer head (slave side)
//   disp         : dispatch output register (master side)
//   wb_valid/wb_wis/wb_rd : writeback retire pulse and its target
//   wb_err       : one-cycle pulse, writeback hit a register that was not busy
//   stall_cycles : saturating count of cycles the head waited on a hazard
//   deadlock     : sticky, head has waited STALL_TIMEOUT consecutive cycles
// ----------------------------------------------------------------------------
module ibuf_issue_scoreboard
  import ibuf_issue_scoreboard_pkg::*;
#(
  parameter  int NUM_WARPS     = DEF_NUM_WARPS,
  parameter  int NUM_REGS      = DEF_NUM_REGS,
  parameter  int PAYLOADW      = DEF_PAYLOADW,
  parameter  int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  localparam int WIS_W         = wis_bits(NUM_WARPS),
  localparam int NR_BITS       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  ibuf_issue_scoreboard_if.slave  ibuf,
  ibuf_issue_scoreboard_if.master disp,
  input  logic                   wb_valid,
  input  logic [WIS_W-1:0]       wb_wis,
  input  logic [NR_BITS-1:0]     wb_rd,
  output logic                   wb_err,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   deadlock
);
  localparam int DATAW = WIS_W + 1 + 4 * NR_BITS + PAYLOADW;
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);

  typedef logic [NUM_REGS-1:0] reg_vec_t;

  // Busy bitmap and masks
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_q, busy_d, busy_eff;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] clear_mask, set_mask;

  reg_vec_t head_busy;
  logic     hazard, out_free, fire, stall, set_en;

  logic                   disp_valid_q, disp_valid_d;
  logic                   wb_err_q, wb_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   deadlock_q, deadlock_d;
  logic [DATAW-1:0]       disp_data;

  // Register 0 is hardwired free, so an entry writing r0 never marks it busy.
  assign set_en = fire & ibuf.wb & (ibuf.rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign clear_mask[gi] = (wb_valid && (wb_wis == WIS_W'(gi)))
                              ? (reg_vec_t'(1) << wb_rd) : '0;
      assign set_mask[gi]   = (set_en && (ibuf.wis == WIS_W'(gi)))
                              ? (reg_vec_t'(1) << ibuf.rd) : '0;
    end
  endgenerate

  // Writeback is applied before the hazard check so a dependent head entry
  // can fire in the same cycle as its producer's writeback.
  assign busy_eff  = busy_q & ~clear_mask;
  assign busy_d    = busy_eff | set_mask;
  assign head_busy = busy_eff[ibuf.wis];

  assign hazard = head_busy[ibuf.rs1] | head_busy[ibuf.rs2] | head_busy[ibuf.rs3]
                | (ibuf.wb & head_busy[ibuf.rd]);

  assign out_free   = ~disp_valid_q | disp.ready;
  assign fire       = ibuf.valid & ~hazard & out_free;
  assign ibuf.ready = fire;

  // Only register hazards count as stalls; output back-pressure does not.
  assign stall = ibuf.valid & hazard;

  always_comb begin
    disp_valid_d = disp_valid_q;
    if (out_free) begin
      disp_valid_d = fire;
    end

    wb_err_d = wb_valid & (wb_rd != '0) & ~busy_q[wb_wis][wb_rd];

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Consecutive-stall run; holds at the timeout value once reached.
    run_d = '0;
    if (stall) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end

    deadlock_d = deadlock_q | (run_d == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      disp_valid_q <= 1'b0;
      wb_err_q     <= 1'b0;
      stall_cnt_q  <= '0;
      run_q        <= '0;
      deadlock_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      disp_valid_q <= disp_valid_d;
      wb_err_q     <= wb_err_d;
      stall_cnt_q  <= stall_cnt_d;
      run_q        <= run_d;
      deadlock_q   <= deadlock_d;
    end
  end

  // Data follows the output slot whenever it can accept; with the slot full
  // and dispatch stalled the fields hold.
  ibuf_issue_scoreboard_pipe_reg #(
    .DATAW (DATAW)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .enable   (out_free),
    .data_in  ({ibuf.wis, ibuf.wb, ibuf.rd, ibuf.rs1, ibuf.rs2, ibuf.rs3, ibuf.payload}),
    .data_out (disp_data)
  );

  assign {disp.wis, disp.wb, disp.rd, disp.rs1, disp.rs2, disp.rs3, disp.payload} = disp_data;
  assign disp.valid   = disp_valid_q;
  assign wb_err       = wb_err_q;
  assign stall_cycles = stall_cnt_q;
  assign deadlock     = deadlock_q;
endmodule

// File: tb/tb_ibuf_issue_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_ibuf_issue_scoreboard
// Directed bench for the issue-slot scoreboard. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1-2 units after the edge.
// ----------------------------------------------------------------------------
module tb_ibuf_issue_scoreboard;
  localparam int PW = 16;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [1:0]  wb_wis;
  logic [5:0]  wb_rd;
  logic        wb_err;
  logic [15:0] stall_cycles;
  logic        deadlock;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

  ibuf_issue_scoreboard_if #(.WIS_W(2), .NR_BITS(6), .PAYLOADW(PW)) ibuf_bus ();
  ibuf_issue_scoreboard_if #(.WIS_W(2), .NR_BITS(6), .PAYLOADW(PW)) disp_bus ();

  ibuf_issue_scoreboard #(
    .NUM_WARPS     (4),
    .NUM_REGS      (64),
    .PAYLOADW      (PW),
    .STALL_TIMEOUT (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ibuf         (ibuf_bus.slave),
    .disp         (disp_bus.master),
    .wb_valid     (wb_valid),
    .wb_wis       (wb_wis),
    .wb_rd        (wb_rd),
    .wb_err       (wb_err),
    .stall_cycles (stall_cycles),
    .deadlock     (deadlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] w, input logic wbf,
                     input logic [5:0] rd, input logic [5:0] rs1,
                     input logic [5:0] rs2, input logic [5:0] rs3,
                     input logic [PW-1:0] pl);
    ibuf_bus.valid   = v;
    ibuf_bus.wis     = w;
    ibuf_bus.wb      = wbf;
    ibuf_bus.rd      = rd;
    ibuf_bus.rs1     = rs1;
    ibuf_bus.rs2     = rs2;
    ibuf_bus.rs3     = rs3;
    ibuf_bus.payload = pl;
    if (v) $display("tx: head w=%0d wb=%0d rd=%0d rs=%0d/%0d/%0d payload=%h", w, wbf, rd, rs1, rs2, rs3, pl);
  endtask

  task automatic do_wb(input logic [1:0] w, input logic [5:0] r);
    wb_valid = 1'b1;
    wb_wis   = w;
    wb_rd    = r;
    $display("tx: writeback w=%0d rd=%0d", w, r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", disp_bus.valid); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock: got %b want 0", deadlock); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
    checks++; if (disp_bus.payload !== 16'h0) begin errors++; $display("FAIL reset_payload: got %h want 0", disp_bus.payload); end
    reset = 1'b0;
    tick();
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", disp_bus.valid); end
  endtask

  task automatic test_independent();
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 2'd0, 1'b1, 6'(i + 1), 6'(40 + i), 6'd50, 6'd0, 16'hA000 + 16'(i));
      #1;
      checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL ind_ready[%0d]: got %b want 1", i, ibuf_bus.ready); end
      tick();
      checks++; if (disp_bus.valid !== 1'b1) begin errors++; $display("FAIL ind_valid[%0d]: got %b want 1", i, disp_bus.valid); end
      checks++; if (disp_bus.rd !== 6'(i + 1)) begin errors++; $display("FAIL ind_rd[%0d]: got %0d want %0d", i, disp_bus.rd, i + 1); end
      checks++; if (disp_bus.payload !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL ind_payload[%0d]: got %h want %h", i, disp_bus.payload, 16'hA000 + 16'(i)); end
    end
    ibuf_bus.valid = 1'b0;
    tick();
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL ind_drain: got %b want 0", disp_bus.valid); end
    // Every issued rd must now block a reader.
    for (int r = 1; r <= 8; r++) begin
      put(1'b1, 2'd0, 1'b0, 6'd0, 6'(r), 6'd0, 6'd0, 16'h0);
      #1;
      checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL ind_busy[%0d]: got ready %b want 0", r, ibuf_bus.ready); end
      ibuf_bus.valid = 1'b0;
      tick();
    end
    // Writebacks to busy registers are legal.
    for (int r = 1; r <= 8; r++) begin
      do_wb(2'd0, 6'(r));
      tick();
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL ind_wb_err[%0d]: got %b want 0", r, wb_err); end
    end
    wb_valid = 1'b0;
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL ind_stall: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_raw();
    put(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0, 16'hB001);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL raw_prod_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd5, 6'd0, 16'hB002);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL raw_hold[%0d]: got %b want 0", k, ibuf_bus.ready); end
      tick();
    end
    exp_stall += 8;
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL raw_stall: got %0d want %0d", stall_cycles, exp_stall); end
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL raw_prod_drained: got %b want 0", disp_bus.valid); end
    do_wb(2'd0, 6'd5);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    wb_valid = 1'b0;
    ibuf_bus.valid = 1'b0;
    checks++; if (disp_bus.valid !== 1'b1) begin errors++; $display("FAIL raw_fire_valid: got %b want 1", disp_bus.valid); end
    checks++; if (disp_bus.payload !== 16'hB002) begin errors++; $display("FAIL raw_fire_payload: got %h want b002", disp_bus.payload); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL raw_wb_err: got %b want 0", wb_err); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL raw_stall_after: got %0d want %0d", stall_cycles, exp_stall); end
    tick();
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL raw_drain: got %b want 0", disp_bus.valid); end
  endtask

  task automatic test_cross_warp();
    put(1'b1, 2'd1, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0, 16'hC001);
    tick();
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, 16'hC002);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL xw_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    checks++; if (disp_bus.valid !== 1'b1) begin errors++; $display("FAIL xw_valid: got %b want 1", disp_bus.valid); end
    checks++; if (disp_bus.wis !== 2'd0) begin errors++; $display("FAIL xw_wis: got %0d want 0", disp_bus.wis); end
    checks++; if (disp_bus.payload !== 16'hC002) begin errors++; $display("FAIL xw_payload: got %h want c002", disp_bus.payload); end
    put(1'b1, 2'd1, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, 16'hC003);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL xw_same_warp_block: got %b want 0", ibuf_bus.ready); end
    ibuf_bus.valid = 1'b0;
    do_wb(2'd1, 6'd7);
    tick();
    wb_valid = 1'b0;
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL xw_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_backpressure();
    disp_bus.ready = 1'b0;
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'h1111);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", k, ibuf_bus.ready); end
      checks++; if (disp_bus.payload !== 16'h1111) begin errors++; $display("FAIL bp_hold[%0d]: got %h want 1111", k, disp_bus.payload); end
      checks++; if (disp_bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, disp_bus.valid); end
      tick();
    end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL bp_stall: got %0d want %0d", stall_cycles, exp_stall); end
    disp_bus.ready = 1'b1;
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    checks++; if (disp_bus.payload !== 16'h2222) begin errors++; $display("FAIL bp_next_payload: got %h want 2222", disp_bus.payload); end
    ibuf_bus.valid = 1'b0;
    tick();
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", disp_bus.valid); end
  endtask

  task automatic test_same_cycle();
    put(1'b1, 2'd0, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0, 16'hD001);
    tick();
    put(1'b1, 2'd0, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0, 16'hD002);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL sc_waw_block: got %b want 0", ibuf_bus.ready); end
    do_wb(2'd0, 6'd3);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL sc_bypass_ready: got %b want 1", ibuf_bus.ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (disp_bus.rd !== 6'd3) begin errors++; $display("FAIL sc_rd: got %0d want 3", disp_bus.rd); end
    checks++; if (disp_bus.payload !== 16'hD002) begin errors++; $display("FAIL sc_payload: got %h want d002", disp_bus.payload); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL sc_wb_err: got %b want 0", wb_err); end
    // Set must have won over the simultaneous clear.
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd3, 6'd0, 6'd0, 16'hD003);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b0) begin errors++; $display("FAIL sc_still_busy: got %b want 0", ibuf_bus.ready); end
    ibuf_bus.valid = 1'b0;
    do_wb(2'd0, 6'd9);
    tick();
    wb_valid = 1'b0;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL sc_wb_err_pulse: got %b want 1", wb_err); end
    tick();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL sc_wb_err_once: got %b want 0", wb_err); end
    do_wb(2'd0, 6'd3);
    tick();
    wb_valid = 1'b0;
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL sc_cleanup_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_deadlock();
    put(1'b1, 2'd0, 1'b1, 6'd10, 6'd0, 6'd0, 6'd0, 16'hE001);
    tick();
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd10, 6'd0, 6'd0, 16'hE002);
    for (int k = 0; k < 19; k++) tick();
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL dl_early: got %b want 0", deadlock); end
    tick();
    checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL dl_rise: got %b want 1", deadlock); end
    exp_stall += 20;
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL dl_stall: got %0d want %0d", stall_cycles, exp_stall); end
    do_wb(2'd0, 6'd10);
    tick();
    wb_valid = 1'b0;
    ibuf_bus.valid = 1'b0;
    checks++; if (disp_bus.payload !== 16'hE002) begin errors++; $display("FAIL dl_release_payload: got %h want e002", disp_bus.payload); end
    tick();
    tick();
    checks++; if (deadlock !== 1'b1) begin errors++; $display("FAIL dl_sticky: got %b want 1", deadlock); end
  endtask

  task automatic test_reset_mid();
    disp_bus.ready = 1'b0;
    put(1'b1, 2'd0, 1'b1, 6'd12, 6'd0, 6'd0, 6'd0, 16'hF001);
    tick();
    ibuf_bus.valid = 1'b0;
    checks++; if (disp_bus.valid !== 1'b1) begin errors++; $display("FAIL rm_held: got %b want 1", disp_bus.valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (disp_bus.valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", disp_bus.valid); end
    checks++; if (disp_bus.payload !== 16'h0) begin errors++; $display("FAIL rm_payload: got %h want 0", disp_bus.payload); end
    checks++; if (deadlock !== 1'b0) begin errors++; $display("FAIL rm_deadlock: got %b want 0", deadlock); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rm_stall: got %0d want 0", stall_cycles); end
    disp_bus.ready = 1'b1;
    put(1'b1, 2'd0, 1'b0, 6'd0, 6'd12, 6'd0, 6'd0, 16'hF002);
    #1;
    checks++; if (ibuf_bus.ready !== 1'b1) begin errors++; $display("FAIL rm_busy_cleared: got %b want 1", ibuf_bus.ready); end
    ibuf_bus.valid = 1'b0;
    do_wb(2'd0, 6'd12);
    tick();
    wb_valid = 1'b0;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL rm_wb_err: got %b want 1", wb_err); end
  endtask

  initial begin
    reset          = 1'b1;
    wb_valid       = 1'b0;
    wb_wis         = '0;
    wb_rd          = '0;
    disp_bus.ready = 1'b1;
    put(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'h0);

    test_reset();
    test_independent();
    test_raw();
    test_cross_warp();
    test_backpressure();
    test_same_cycle();
    test_deadlock();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
